// File: rtl/int_rs_multi.sv
// int_rs_multi: multi-issue integer reservation station with an age-ordered, collapsing entry array.
// Optional macro INT_RS_MULTI_CDB_BYPASS_EN lets same-cycle CDB tags satisfy issue eligibility.
module int_rs_multi #(
    parameter int DEPTH     = 8,
    parameter int DISP_W    = 2,
    parameter int ISS_W     = 2,
    parameter int CDB_W     = 2,
    parameter int PRF_IDX   = 6,
    parameter int PAYLOAD_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ds_valid    [DISP_W],
    output logic                   ds_ready,
    input  logic [PRF_IDX-1:0]     ds_rs1_phy  [DISP_W],
    input  logic [PRF_IDX-1:0]     ds_rs2_phy  [DISP_W],
    input  logic                   ds_rs1_rdy  [DISP_W],
    input  logic                   ds_rs2_rdy  [DISP_W],
    input  logic [PAYLOAD_W-1:0]   ds_payload  [DISP_W],
    input  logic                   cdb_valid   [CDB_W],
    input  logic [PRF_IDX-1:0]     cdb_rd_phy  [CDB_W],
    output logic                   iss_valid   [ISS_W],
    input  logic                   iss_ready   [ISS_W],
    output logic [PRF_IDX-1:0]     iss_rs1_phy [ISS_W],
    output logic [PRF_IDX-1:0]     iss_rs2_phy [ISS_W],
    output logic [PAYLOAD_W-1:0]   iss_payload [ISS_W],
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                 valid_reg   [DEPTH];
    logic                 valid_next  [DEPTH];
    logic [PRF_IDX-1:0]   rs1_reg     [DEPTH];
    logic [PRF_IDX-1:0]   rs1_next    [DEPTH];
    logic [PRF_IDX-1:0]   rs2_reg     [DEPTH];
    logic [PRF_IDX-1:0]   rs2_next    [DEPTH];
    logic                 rs1_rdy_reg [DEPTH];
    logic                 rs1_rdy_next[DEPTH];
    logic                 rs2_rdy_reg [DEPTH];
    logic                 rs2_rdy_next[DEPTH];
    logic [PAYLOAD_W-1:0] payload_reg [DEPTH];
    logic [PAYLOAD_W-1:0] payload_next[DEPTH];
    logic [OCC_W-1:0]     occ_reg;
    logic [OCC_W-1:0]     occ_next;

    logic                 rs1_hit     [DEPTH];
    logic                 rs2_hit     [DEPTH];
    logic                 ds_rs1_hit  [DISP_W];
    logic                 ds_rs2_hit  [DISP_W];
    logic                 elig        [DEPTH];
    logic                 removed     [DEPTH];
    logic                 sel_valid   [ISS_W];
    logic [IDX_W-1:0]     sel_idx     [ISS_W];
    logic [OCC_W-1:0]     wp;
    logic [OCC_W-1:0]     slot;

    // Tag matches against every live CDB channel, for stored and dispatching sources alike.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rs1_hit[i] = 1'b0;
            rs2_hit[i] = 1'b0;
            for (int c = 0; c < CDB_W; c++) begin
                if (cdb_valid[c] && cdb_rd_phy[c] == rs1_reg[i]) rs1_hit[i] = 1'b1;
                if (cdb_valid[c] && cdb_rd_phy[c] == rs2_reg[i]) rs2_hit[i] = 1'b1;
            end
        end
        for (int j = 0; j < DISP_W; j++) begin
            ds_rs1_hit[j] = 1'b0;
            ds_rs2_hit[j] = 1'b0;
            for (int c = 0; c < CDB_W; c++) begin
                if (cdb_valid[c] && cdb_rd_phy[c] == ds_rs1_phy[j]) ds_rs1_hit[j] = 1'b1;
                if (cdb_valid[c] && cdb_rd_phy[c] == ds_rs2_phy[j]) ds_rs2_hit[j] = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
`ifdef INT_RS_MULTI_CDB_BYPASS_EN
            assign elig[gi] = valid_reg[gi] && (rs1_rdy_reg[gi] || rs1_hit[gi])
                                            && (rs2_rdy_reg[gi] || rs2_hit[gi]);
`else
            assign elig[gi] = valid_reg[gi] && rs1_rdy_reg[gi] && rs2_rdy_reg[gi];
`endif
        end
    endgenerate

    // Lane k takes the (k+1)-th eligible entry counting from index 0 (oldest).
    always_comb begin : p_select
        int rank;
        rank = 0;
        for (int k = 0; k < ISS_W; k++) begin
            sel_valid[k] = 1'b0;
            sel_idx[k]   = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i]) begin
                for (int k = 0; k < ISS_W; k++) begin
                    if (rank == k) begin
                        sel_valid[k] = 1'b1;
                        sel_idx[k]   = IDX_W'(i);
                    end
                end
                rank = rank + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            removed[i] = 1'b0;
            for (int k = 0; k < ISS_W; k++) begin
                if (sel_valid[k] && iss_ready[k] && sel_idx[k] == IDX_W'(i)) removed[i] = 1'b1;
            end
        end
    end

    // Survivors are packed toward index 0 in age order; new uops append behind them.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_next[i]   = 1'b0;
            rs1_next[i]     = rs1_reg[i];
            rs2_next[i]     = rs2_reg[i];
            rs1_rdy_next[i] = 1'b0;
            rs2_rdy_next[i] = 1'b0;
            payload_next[i] = payload_reg[i];
        end
        wp   = '0;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_reg[i] && !removed[i]) begin
                valid_next[wp[IDX_W-1:0]]   = 1'b1;
                rs1_next[wp[IDX_W-1:0]]     = rs1_reg[i];
                rs2_next[wp[IDX_W-1:0]]     = rs2_reg[i];
                rs1_rdy_next[wp[IDX_W-1:0]] = rs1_rdy_reg[i] || rs1_hit[i];
                rs2_rdy_next[wp[IDX_W-1:0]] = rs2_rdy_reg[i] || rs2_hit[i];
                payload_next[wp[IDX_W-1:0]] = payload_reg[i];
                wp = wp + OCC_W'(1);
            end
        end
        occ_next = wp;
        for (int j = 0; j < DISP_W; j++) begin
            slot = wp + OCC_W'(j);
            if (ds_ready && ds_valid[j] && slot < OCC_W'(DEPTH)) begin
                valid_next[slot[IDX_W-1:0]]   = 1'b1;
                rs1_next[slot[IDX_W-1:0]]     = ds_rs1_phy[j];
                rs2_next[slot[IDX_W-1:0]]     = ds_rs2_phy[j];
                rs1_rdy_next[slot[IDX_W-1:0]] = ds_rs1_rdy[j] || ds_rs1_hit[j];
                rs2_rdy_next[slot[IDX_W-1:0]] = ds_rs2_rdy[j] || ds_rs2_hit[j];
                payload_next[slot[IDX_W-1:0]] = ds_payload[j];
                occ_next = occ_next + OCC_W'(1);
            end
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) valid_next[i] = 1'b0;
            occ_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i]   <= 1'b0;
                rs1_rdy_reg[i] <= 1'b0;
                rs2_rdy_reg[i] <= 1'b0;
            end
            occ_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i]   <= valid_next[i];
                rs1_rdy_reg[i] <= rs1_rdy_next[i];
                rs2_rdy_reg[i] <= rs2_rdy_next[i];
            end
            occ_reg <= occ_next;
        end
    end

    // Tags and payload are qualified by valid_reg, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            rs1_reg[i]     <= rs1_next[i];
            rs2_reg[i]     <= rs2_next[i];
            payload_reg[i] <= payload_next[i];
        end
    end

    assign ds_ready  = (OCC_W'(DEPTH) - occ_reg) >= OCC_W'(DISP_W);
    assign occupancy = occ_reg;

    generate
        for (genvar gi = 0; gi < ISS_W; gi++) begin : g_lane
            assign iss_valid[gi]   = sel_valid[gi];
            assign iss_rs1_phy[gi] = rs1_reg[sel_idx[gi]];
            assign iss_rs2_phy[gi] = rs2_reg[sel_idx[gi]];
            assign iss_payload[gi] = payload_reg[sel_idx[gi]];
        end
    endgenerate
endmodule
